johnson_decoder: RTL

//  Receive-side partner of the Johnson (twisted-ring) counter. It samples an N-bit

---
 rtl/johnson_decoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/johnson_decoder.sv
// Decodes an N-bit Johnson code to a binary index, tracks step direction against the
// previous legal sample and keeps a saturating count of out-of-sequence and illegal codes.
module johnson_decoder #(
  parameter int unsigned N         = 4,
  parameter int unsigned ERR_CNT_W = 8,
  localparam int unsigned IW       = $clog2(2 * N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         code_in,
  input  logic                 code_valid,
  input  logic                 clr_err,
  output logic [IW-1:0]        idx_out,
  output logic                 idx_valid,
  output logic                 dir_up,
  output logic                 dir_dn,
  output logic                 step_err,
  output logic                 illegal,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 idx_valid_q, idx_valid_d;
  logic                 dir_up_q, dir_up_d;
  logic                 dir_dn_q, dir_dn_d;
  logic                 step_err_q, step_err_d;
  logic                 illegal_q, illegal_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 err_inc;

  logic                 dec_legal;
  logic [IW-1:0]        dec_idx;
  logic [IW-1:0]        idx_plus, idx_minus;

  // Johnson pattern for index k: 1..N fill ones from the MSB, N+1..2N-1 fill zeros from the MSB.
  function automatic logic [N-1:0] johnson_code(input int unsigned k);
    logic [N-1:0] c;
    for (int unsigned i = 0; i < N; i++) begin
      if (k <= N) c[i] = (i + k >= N);
      else        c[i] = (i + k < 2 * N);
    end
    return c;
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int unsigned k = 0; k < 2 * N; k++) begin
      if (code_in == johnson_code(k)) begin
        dec_legal = 1'b1;
        dec_idx   = IW'(k);
      end
    end
  end

  assign idx_plus  = (idx_q == IW'(2 * N - 1)) ? '0 : idx_q + 1'b1;
  assign idx_minus = (idx_q == '0) ? IW'(2 * N - 1) : idx_q - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StUnlocked;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      step_err_q  <= 1'b0;
      illegal_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      step_err_q  <= step_err_d;
      illegal_q   <= illegal_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (code_valid) state_d = dec_legal ? StLocked : StUnlocked;
  end

  always_comb begin
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    dir_up_d    = 1'b0;
    dir_dn_d    = 1'b0;
    step_err_d  = 1'b0;
    illegal_d   = 1'b0;
    err_inc     = 1'b0;
    if (code_valid) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        err_inc   = 1'b1;
      end else begin
        idx_d       = dec_idx;
        idx_valid_d = 1'b1;
        // The first legal sample after losing lock only anchors; it is never a step.
        if (state_q == StLocked && dec_idx != idx_q) begin
          if (dec_idx == idx_plus) begin
            dir_up_d = 1'b1;
          end else if (dec_idx == idx_minus) begin
            dir_dn_d = 1'b1;
          end else begin
            step_err_d = 1'b1;
            err_inc    = 1'b1;
          end
        end
      end
    end
    err_d = err_q;
    if (clr_err) err_d = '0;
    else if (err_inc && err_q != '1) err_d = err_q + 1'b1;
  end

  assign idx_out   = idx_q;
  assign idx_valid = idx_valid_q;
  assign dir_up    = dir_up_q;
  assign dir_dn    = dir_dn_q;
  assign step_err  = step_err_q;
  assign illegal   = illegal_q;
  assign locked    = (state_q == StLocked);
  assign err_cnt   = err_q;

endmodule
